// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register offsets and FSM states.
package irq_pkg;

  localparam int IRQ_MAX = 8;

  localparam logic [7:0] OFF_PEND  = 8'd0;
  localparam logic [7:0] OFF_MASK  = 8'd1;
  localparam logic [7:0] OFF_MODE  = 8'd2;
  localparam logic [7:0] OFF_INSVC = 8'd3;
  localparam logic [7:0] OFF_STAT  = 8'd4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Find-first-set encoder: lowest set bit wins, index is 3 bits wide (up to 8 inputs).
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   index
);

  always_comb begin
    valid = 1'b0;
    index = 3'd0;
    // Scan downward so the lowest set index is the last one assigned.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised, nesting interrupt controller with memory-mapped PEND/MASK/MODE/INSVC/STAT
// registers and a one-request handshake towards the control unit.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ    = 8,
  parameter logic [15:0] VEC_BASE   = 16'h0008,
  parameter int          VEC_STRIDE = 2,
  parameter logic [7:0]  REG_BASE   = 8'h20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [7:0]         io_addr,
  input  logic [7:0]         io_wdata,
  input  logic               io_we,
  input  logic               io_re,
  output logic [7:0]         io_rdata,
  output logic               int_req,
  output logic [15:0]        int_vector,
  input  logic               int_ack,
  input  logic               int_reti
);

  localparam int N = NUM_IRQ;

  logic [N-1:0] sync1_reg, sync2_reg, sync3_reg, rise_reg;
  logic [N-1:0] pend_reg, mask_reg, mode_reg, insvc_reg;
  logic [N-1:0] pend_next, insvc_next;
  logic [N-1:0] allowed, id_hot, top_hot, w1c, ack_clr, lvl2edge;
  state_t       state_reg;
  logic [2:0]   id_reg;
  logic         cand_valid, top_valid;
  logic [2:0]   cand_idx, top_idx;
  logic [15:0]  cand_vec;
  logic [7:0]   off;
  logic         wr_pend, wr_mode, ack_take, id_live;

  assign off      = io_addr - REG_BASE;
  assign wr_pend  = io_we && (off == OFF_PEND);
  assign wr_mode  = io_we && (off == OFF_MODE);
  assign ack_take = (state_reg == REQ) && int_ack;
  assign cand_vec = VEC_BASE + 16'(VEC_STRIDE) * {13'b0, cand_idx};

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      // Only strictly higher priority than the top in-service channel may nest.
      assign allowed[gi]  = !top_valid || (3'(gi) < top_idx);
      assign id_hot[gi]   = (id_reg == 3'(gi));
      assign top_hot[gi]  = top_valid && (top_idx == 3'(gi));
      assign w1c[gi]      = wr_pend && io_wdata[gi];
      assign ack_clr[gi]  = ack_take && id_hot[gi];
      assign lvl2edge[gi] = wr_mode && !mode_reg[gi] && io_wdata[gi];
      assign pend_next[gi] = mode_reg[gi]
                           ? (rise_reg[gi] | (pend_reg[gi] & ~w1c[gi] & ~ack_clr[gi]))
                           : (lvl2edge[gi] ? 1'b0 : sync3_reg[gi]);
    end
  endgenerate

  // Retire first, then record the newly accepted channel.
  assign insvc_next = (insvc_reg & ~(int_reti ? top_hot : '0)) | (ack_take ? id_hot : '0);
  assign id_live    = |(pend_reg & mask_reg & id_hot);

  irq_prio_enc #(.N(N)) u_cand (
    .req   (pend_reg & mask_reg & allowed),
    .valid (cand_valid),
    .index (cand_idx)
  );

  irq_prio_enc #(.N(N)) u_top (
    .req   (insvc_reg),
    .valid (top_valid),
    .index (top_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      sync3_reg <= '0;
      rise_reg  <= '0;
      pend_reg  <= '0;
      mask_reg  <= '0;
      mode_reg  <= '1;
      insvc_reg <= '0;
    end else begin
      sync1_reg <= irq_in;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      rise_reg  <= sync2_reg & ~sync3_reg;
      pend_reg  <= pend_next;
      insvc_reg <= insvc_next;
      if (io_we && off == OFF_MASK) mask_reg <= io_wdata[N-1:0];
      if (wr_mode) mode_reg <= io_wdata[N-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      id_reg     <= 3'd0;
      int_req    <= 1'b0;
      int_vector <= VEC_BASE;
    end else begin
      case (state_reg)
        IDLE: if (cand_valid) begin
          state_reg  <= REQ;
          id_reg     <= cand_idx;
          int_req    <= 1'b1;
          int_vector <= cand_vec;
        end
        REQ: if (int_ack || !id_live) begin
          state_reg <= IDLE;
          int_req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !io_re) begin
      io_rdata <= 8'h00;
    end else begin
      case (off)
        OFF_PEND:  io_rdata <= 8'(pend_reg);
        OFF_MASK:  io_rdata <= 8'(mask_reg);
        OFF_MODE:  io_rdata <= 8'(mode_reg);
        OFF_INSVC: io_rdata <= 8'(insvc_reg);
        OFF_STAT:  io_rdata <= {int_req, 4'b0000, id_reg};
        default:   io_rdata <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: an 8-channel instance plus a 3-channel instance for width checks.
module tb_irq_ctrl;

  localparam logic [7:0] A_PEND  = 8'h20;
  localparam logic [7:0] A_MASK  = 8'h21;
  localparam logic [7:0] A_MODE  = 8'h22;
  localparam logic [7:0] A_INSVC = 8'h23;
  localparam logic [7:0] A_STAT  = 8'h24;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic [2:0]  irq3;
  logic [7:0]  io_addr, io_wdata;
  logic        io_we, io_re, int_ack, int_reti;
  logic [7:0]  io_rdata, io_rdata3;
  logic        int_req, int_req3;
  logic [15:0] int_vector, int_vector3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;
  assign irq3 = irq[2:0];

  irq_ctrl dut (
    .clk(clk), .rst(rst), .irq_in(irq), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata), .int_req(int_req),
    .int_vector(int_vector), .int_ack(int_ack), .int_reti(int_reti)
  );

  irq_ctrl #(.NUM_IRQ(3)) dut3 (
    .clk(clk), .rst(rst), .irq_in(irq3), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata3), .int_req(int_req3),
    .int_vector(int_vector3), .int_ack(int_ack), .int_reti(int_reti)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    io_addr = a; io_wdata = d; io_we = 1'b1;
    tick(1);
    io_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    io_addr = a; io_re = 1'b1;
    tick(1);
    io_re = 1'b0;
  endtask

  // One-cycle pulse on the given channels, then wait until the request cycle (k+4).
  task automatic pulse_wait(input logic [7:0] ch);
    irq = ch;
    tick(1);
    irq = 8'h00;
    tick(4);
  endtask

  task automatic ack_only();
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
  endtask

  task automatic reti_only();
    int_reti = 1'b1; tick(1); int_reti = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = 8'h00; io_addr = 8'h00; io_wdata = 8'h00;
    io_we = 1'b0; io_re = 1'b0; int_ack = 1'b0; int_reti = 1'b0;
    tick(3);
    chk("rst_req", {15'd0, int_req}, 16'h0000);
    chk("rst_vec", int_vector, 16'h0008);
    chk("rst_rdata", {8'd0, io_rdata}, 16'h0000);
    rst = 1'b0;
    rd(A_MODE);  chk("rst_mode", {8'd0, io_rdata}, 16'h00FF);
    chk("rst_mode3", {8'd0, io_rdata3}, 16'h0007);
    rd(A_MASK);  chk("rst_mask", {8'd0, io_rdata}, 16'h0000);
    tick(1);     chk("rdata_idle", {8'd0, io_rdata}, 16'h0000);

    // 1: single channel, latency and ack
    wr(A_MASK, 8'h01);
    irq = 8'h01; tick(1); irq = 8'h00; tick(3);
    chk("t1_req_k3", {15'd0, int_req}, 16'h0000);
    tick(1);
    chk("t1_req_k4", {15'd0, int_req}, 16'h0001);
    chk("t1_vec", int_vector, 16'h0008);
    ack_only();
    chk("t1_req_drop", {15'd0, int_req}, 16'h0000);
    rd(A_INSVC); chk("t1_insvc", {8'd0, io_rdata}, 16'h0001);
    rd(A_PEND);  chk("t1_pend", {8'd0, io_rdata}, 16'h0000);
    reti_only();
    rd(A_INSVC); chk("t1_insvc_ret", {8'd0, io_rdata}, 16'h0000);

    // 2: simultaneous ch5 and ch2, ch2 wins; ch5 follows after retirement
    wr(A_MASK, 8'hFF);
    pulse_wait(8'h24);
    chk("t2_req", {15'd0, int_req}, 16'h0001);
    chk("t2_vec", int_vector, 16'h000C);
    rd(A_STAT);  chk("t2_stat", {8'd0, io_rdata}, 16'h0082);
    ack_only();
    reti_only();
    chk("t2_blocked", {15'd0, int_req}, 16'h0000);
    tick(1);
    chk("t2_req5", {15'd0, int_req}, 16'h0001);
    chk("t2_vec5", int_vector, 16'h0012);
    ack_only();
    reti_only();

    // 3: nesting by priority, lower priority held off until in-service retires
    pulse_wait(8'h08);
    chk("t3_vec3", int_vector, 16'h000E);
    ack_only();
    pulse_wait(8'h02);
    chk("t3_req1", {15'd0, int_req}, 16'h0001);
    chk("t3_vec1", int_vector, 16'h000A);
    ack_only();
    rd(A_INSVC); chk("t3_insvc", {8'd0, io_rdata}, 16'h000A);
    pulse_wait(8'h40);
    chk("t3_no_req6", {15'd0, int_req}, 16'h0000);
    rd(A_PEND);  chk("t3_pend6", {8'd0, io_rdata}, 16'h0040);
    reti_only();
    tick(1);
    chk("t3_still_blk", {15'd0, int_req}, 16'h0000);
    pulse_wait(8'h04);
    chk("t3_vec2", int_vector, 16'h000C);
    int_ack = 1'b1; int_reti = 1'b1; tick(1); int_ack = 1'b0; int_reti = 1'b0;
    rd(A_INSVC); chk("t3_reti_ack", {8'd0, io_rdata}, 16'h0004);
    chk("t3_blk6", {15'd0, int_req}, 16'h0000);
    reti_only();
    chk("t3_pre6", {15'd0, int_req}, 16'h0000);
    tick(1);
    chk("t3_req6", {15'd0, int_req}, 16'h0001);
    chk("t3_vec6", int_vector, 16'h0014);
    ack_only();
    reti_only();

    // ack while idle is ignored
    ack_only();
    rd(A_INSVC); chk("idle_ack", {8'd0, io_rdata}, 16'h0000);

    // 4: level mode, source drops before ack
    wr(A_MODE, 8'hEF);
    irq = 8'h10; tick(5);
    chk("t4_req", {15'd0, int_req}, 16'h0001);
    chk("t4_vec", int_vector, 16'h0010);
    irq = 8'h00; tick(4);
    chk("t4_req_hold", {15'd0, int_req}, 16'h0001);
    tick(1);
    chk("t4_req_drop", {15'd0, int_req}, 16'h0000);
    rd(A_INSVC); chk("t4_insvc", {8'd0, io_rdata}, 16'h0000);
    wr(A_MODE, 8'hFF);

    // 5: W1C collides with a new edge; the set wins
    wr(A_MASK, 8'h00);
    irq = 8'h10; tick(1); irq = 8'h00; tick(2);
    wr(A_PEND, 8'h10);
    rd(A_PEND);  chk("t5_set_wins", {8'd0, io_rdata}, 16'h0010);
    wr(A_PEND, 8'h10);
    rd(A_PEND);  chk("t5_w1c", {8'd0, io_rdata}, 16'h0000);
    rd(8'h25);   chk("t5_unmapped", {8'd0, io_rdata}, 16'h0000);
    rd(8'h1F);   chk("t5_below", {8'd0, io_rdata}, 16'h0000);

    // 6: reset during an active request; narrow instance masks register width
    wr(A_MASK, 8'hFF);
    pulse_wait(8'h01);
    chk("t6_req", {15'd0, int_req}, 16'h0001);
    rst = 1'b1; tick(1);
    chk("t6_rst_req", {15'd0, int_req}, 16'h0000);
    chk("t6_rst_vec", int_vector, 16'h0008);
    rst = 1'b0;
    rd(A_MASK);  chk("t6_mask", {8'd0, io_rdata}, 16'h0000);
    rd(A_MODE);  chk("t6_mode", {8'd0, io_rdata}, 16'h00FF);
    wr(A_MASK, 8'hFF);
    rd(A_MASK);
    chk("t6_mask8", {8'd0, io_rdata}, 16'h00FF);
    chk("t6_mask3", {8'd0, io_rdata3}, 16'h0007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
